// File: rtl/gic_master.sv
// gic_master: Wishbone classic slave that carries one bus cycle at a time
// across the 4-bit GIC link to a remote gic_slave and returns its reply.
module gic_master #(
    parameter int unsigned TIMEOUT = 1023,
    parameter logic [3:0]  IDLE    = 4'b1111
) (
    input  logic        wbs_clk_i,
    input  logic        wbs_rst_i,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic        wbs_we_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_cyc_i,
    input  logic [2:0]  wbs_cti_i,
    input  logic [1:0]  wbs_bte_i,
    output logic [31:0] wbs_dat_o,
    output logic        wbs_ack_o,
    output logic        wbs_err_o,
    output logic        wbs_rty_o,
    input  logic [3:0]  gic_dat_i,
    output logic [3:0]  gic_dat_o
);

    localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
    localparam logic [3:0] NIB_INIT  = 4'b1010;
    localparam logic [3:0] NIB_SINIT = 4'b0101;
    localparam logic [3:0] NIB_ACK   = 4'b1000;
    localparam logic [3:0] NIB_RTY   = 4'b0010;
    // Salt per 8-nibble group so all-0 / all-1 frames never check out
    localparam logic [3:0] CK_SALT   = 4'b1100;

    typedef enum logic [3:0] {
        S_IDLE, S_INIT, S_CMD, S_SEL, S_ADR, S_DAT, S_CKSUM,
        S_WAIT, S_RESP, S_RDAT, S_RCKSUM, S_DONE
    } state_t;

    typedef enum logic [1:0] {R_ACK = 2'd0, R_ERR = 2'd1, R_RTY = 2'd2} res_t;

    state_t        state_q, state_d;
    res_t          res_q, res_d;
    logic [2:0]    cnt_q, cnt_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic [31:0]   rsh_q, rsh_d;
    logic [3:0]    rxor_q, rxor_d;
    logic [31:0]   rdat_q, rdat_d;
    logic [3:0]    gic_q, gic_d;
    logic [31:0]   adr_q, dat_q;
    logic [3:0]    sel_q;
    logic          we_q;
    logic          load;
    logic [3:0]    tx_ck;
    logic          done_v;

    // cti/bte carry no meaning for classic single cycles
    logic unused_ok;
    assign unused_ok = ^{wbs_cti_i, wbs_bte_i};

    function automatic logic [3:0] nib_xor(input logic [31:0] v);
        logic [3:0] x;
        x = 4'h0;
        for (int i = 0; i < 8; i++) x ^= v[i*4 +: 4];
        return x;
    endfunction

    assign tx_ck = sel_q ^ nib_xor(adr_q) ^ CK_SALT
                 ^ (we_q ? (nib_xor(dat_q) ^ CK_SALT) : 4'h0);

    // Next-state, reply decode and the nibble to drive next cycle
    always_comb begin
        state_d = state_q;
        res_d   = res_q;
        cnt_d   = cnt_q;
        tmo_d   = tmo_q;
        rsh_d   = rsh_q;
        rxor_d  = rxor_q;
        rdat_d  = rdat_q;
        load    = 1'b0;
        gic_d   = IDLE;
        case (state_q)
            S_IDLE: if (wbs_cyc_i && wbs_stb_i) begin
                load    = 1'b1;
                state_d = S_INIT;
            end
            S_INIT: state_d = S_CMD;
            S_CMD:  state_d = S_SEL;
            S_SEL: begin
                state_d = S_ADR;
                cnt_d   = 3'd0;
            end
            S_ADR: begin
                cnt_d = cnt_q + 3'd1;
                if (cnt_q == 3'd7) state_d = we_q ? S_DAT : S_CKSUM;
            end
            S_DAT: begin
                cnt_d = cnt_q + 3'd1;
                if (cnt_q == 3'd7) state_d = S_CKSUM;
            end
            S_CKSUM: begin
                state_d = S_WAIT;
                tmo_d   = '0;
            end
            S_WAIT: begin
                if (gic_dat_i == NIB_SINIT) begin
                    state_d = S_RESP;
                end else if (tmo_q == TMO_LAST) begin
                    state_d = S_DONE;
                    res_d   = R_ERR;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            S_RESP: begin
                // Anything that is not a clean one-hot ack/err/rty is an error
                case (gic_dat_i)
                    NIB_ACK: res_d = R_ACK;
                    NIB_RTY: res_d = R_RTY;
                    default: res_d = R_ERR;
                endcase
                if (gic_dat_i == NIB_ACK && !we_q) begin
                    state_d = S_RDAT;
                    cnt_d   = 3'd0;
                    rxor_d  = 4'h0;
                end else begin
                    state_d = S_DONE;
                end
            end
            S_RDAT: begin
                rsh_d  = {rsh_q[27:0], gic_dat_i};
                rxor_d = rxor_q ^ gic_dat_i;
                cnt_d  = cnt_q + 3'd1;
                if (cnt_q == 3'd7) state_d = S_RCKSUM;
            end
            S_RCKSUM: begin
                state_d = S_DONE;
                if (gic_dat_i == (rxor_q ^ CK_SALT)) begin
                    rdat_d = rsh_q;
                    res_d  = R_ACK;
                end else begin
                    res_d  = R_ERR;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        case (state_d)
            S_INIT:  gic_d = NIB_INIT;
            S_CMD:   gic_d = {we_q, 3'b000};
            S_SEL:   gic_d = sel_q;
            S_ADR:   gic_d = adr_q[{~cnt_d, 2'b00} +: 4];
            S_DAT:   gic_d = dat_q[{~cnt_d, 2'b00} +: 4];
            S_CKSUM: gic_d = tx_ck;
            default: gic_d = IDLE;
        endcase
    end

    // Control state; reset aborts any frame in flight without a bus reply
    always_ff @(posedge wbs_clk_i) begin
        if (wbs_rst_i) begin
            state_q <= S_IDLE;
            res_q   <= R_ERR;
            cnt_q   <= '0;
            tmo_q   <= '0;
            rsh_q   <= '0;
            rxor_q  <= '0;
            rdat_q  <= '0;
            gic_q   <= IDLE;
        end else begin
            state_q <= state_d;
            res_q   <= res_d;
            cnt_q   <= cnt_d;
            tmo_q   <= tmo_d;
            rsh_q   <= rsh_d;
            rxor_q  <= rxor_d;
            rdat_q  <= rdat_d;
            gic_q   <= gic_d;
        end
    end

    // Request snapshot; bus inputs are ignored once the frame has started
    always_ff @(posedge wbs_clk_i) begin
        if (load) begin
            adr_q <= wbs_adr_i;
            dat_q <= wbs_dat_i;
            sel_q <= wbs_sel_i;
            we_q  <= wbs_we_i;
        end
    end

    // Pulse is withheld if the master abandoned the cycle
    assign done_v    = (state_q == S_DONE) && wbs_cyc_i;
    assign wbs_ack_o = done_v && (res_q == R_ACK);
    assign wbs_err_o = done_v && (res_q == R_ERR);
    assign wbs_rty_o = done_v && (res_q == R_RTY);
    assign wbs_dat_o = rdat_q;
    assign gic_dat_o = gic_q;

endmodule

// File: tb/tb_gic_master.sv
// tb_gic_master: random and directed bus cycles against a frame/reply model,
// with frame and result scoreboards checked by independent monitors.
module tb_gic_master;

    localparam int TMO = 15;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] wbs_adr_i, wbs_dat_i, wbs_dat_o;
    logic [3:0]  wbs_sel_i;
    logic        wbs_we_i, wbs_stb_i, wbs_cyc_i;
    logic [2:0]  wbs_cti_i;
    logic [1:0]  wbs_bte_i;
    logic        wbs_ack_o, wbs_err_o, wbs_rty_o;
    logic [3:0]  gic_dat_i, gic_dat_o;

    gic_master #(.TIMEOUT(TMO)) dut (
        .wbs_clk_i(clk), .wbs_rst_i(rst),
        .wbs_adr_i(wbs_adr_i), .wbs_dat_i(wbs_dat_i), .wbs_sel_i(wbs_sel_i),
        .wbs_we_i(wbs_we_i), .wbs_stb_i(wbs_stb_i), .wbs_cyc_i(wbs_cyc_i),
        .wbs_cti_i(wbs_cti_i), .wbs_bte_i(wbs_bte_i),
        .wbs_dat_o(wbs_dat_o), .wbs_ack_o(wbs_ack_o), .wbs_err_o(wbs_err_o),
        .wbs_rty_o(wbs_rty_o), .gic_dat_i(gic_dat_i), .gic_dat_o(gic_dat_o)
    );

    always #5 clk = ~clk;

    typedef struct { logic [79:0] v; int len; } frame_t;
    typedef struct { int kind; logic [31:0] data; } res_t;   // kind: 0 ack, 1 err, 2 rty

    frame_t      frm_q[$];
    res_t        exp_q[$];
    int          n_chk = 0, n_pass = 0;
    logic [31:0] model_rd = 32'h0;
    bit          mon_off = 1'b0;
    bit          in_frame = 1'b0;
    int          idx;
    frame_t      cur;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic drop();
        wbs_cyc_i = 1'b0;
        wbs_stb_i = 1'b0;
    endtask

    function automatic logic [3:0] junk();
        logic [3:0] n = 4'($urandom);
        if (n == 4'b0101) n = 4'hF;
        return n;
    endfunction

    // Frame as the spec lists it: header, sel, address, optional data, checksum
    function automatic frame_t mk_frame(input bit we, input logic [31:0] adr,
                                        input logic [31:0] dat, input logic [3:0] sel);
        frame_t f;
        logic [3:0] ck, x;
        f.v = '0; f.len = 0;
        f.v[4*f.len +: 4] = 4'b1010;      f.len++;
        f.v[4*f.len +: 4] = {we, 3'b000}; f.len++;
        f.v[4*f.len +: 4] = sel;          f.len++;
        ck = sel ^ 4'b1100;
        for (int i = 0; i < 8; i++) begin
            x = adr[31-4*i -: 4];
            f.v[4*f.len +: 4] = x; f.len++; ck ^= x;
        end
        if (we) begin
            ck ^= 4'b1100;
            for (int i = 0; i < 8; i++) begin
                x = dat[31-4*i -: 4];
                f.v[4*f.len +: 4] = x; f.len++; ck ^= x;
            end
        end
        f.v[4*f.len +: 4] = ck; f.len++;
        return f;
    endfunction

    // Issue one cycle in the current cycle T, play the remote slave, check pulse timing.
    // dly: WAIT cycles before slave_initiate (>= TMO means the slave never answers).
    // ckx: XORed into the correct read checksum (0 keeps it valid).
    task automatic run_txn(input bit we, input logic [31:0] adr, input logic [31:0] dat,
                           input logic [3:0] sel, input int dly, input logic [3:0] resp,
                           input logic [31:0] rdata, input logic [3:0] ckx, input bit drp);
        frame_t f;
        res_t r;
        int pk, first, kind;
        bit valid, rd_path;
        logic [3:0] good_ck, sent_ck, n;
        f = mk_frame(we, adr, dat, sel);
        frm_q.push_back(f);
        good_ck = 4'b1100;
        for (int j = 0; j < 8; j++) good_ck ^= rdata[31-4*j -: 4];
        sent_ck = good_ck ^ ckx;
        rd_path = 1'b0;
        if (dly >= TMO) begin
            kind = 1; pk = TMO;
        end else begin
            valid = !resp[0] && ($countones(resp[3:1]) == 1);
            kind  = !valid ? 1 : resp[3] ? 0 : resp[2] ? 1 : 2;
            if (kind == 0 && !we) begin
                rd_path = 1'b1;
                pk = dly + 11;
                if (sent_ck == good_ck) model_rd = rdata;
                else kind = 1;
            end else begin
                pk = dly + 2;
            end
        end
        r.kind = kind; r.data = model_rd;
        if (!drp) exp_q.push_back(r);
        wbs_adr_i = adr; wbs_dat_i = dat; wbs_sel_i = sel; wbs_we_i = we;
        wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1;
        step();
        chk("init_latency", gic_dat_o, 4'b1010);
        if (drp) drop();
        wbs_adr_i = $urandom; wbs_dat_i = $urandom;
        wbs_sel_i = 4'($urandom); wbs_we_i = 1'($urandom);
        repeat (f.len) step();
        first = -1;
        for (int k = 0; k <= pk; k++) begin
            if (dly < TMO && k == dly) n = 4'b0101;
            else if (dly < TMO && k == dly + 1) n = resp;
            else if (rd_path && k >= dly + 2 && k <= dly + 9) n = rdata[31-4*(k-dly-2) -: 4];
            else if (rd_path && k == dly + 10) n = sent_ck;
            else n = junk();
            gic_dat_i = n;
            if ((wbs_ack_o | wbs_err_o | wbs_rty_o) && first < 0) first = k;
            if (k < pk) step();
        end
        chk("pulse_cycle", first, drp ? -1 : pk);
        step();
        gic_dat_i = 4'hF;
    endtask

    // Frame monitor: every non-idle burst must be the next expected frame, then idle
    always @(negedge clk) begin
        if (rst || mon_off) begin
            in_frame = 1'b0;
        end else if (in_frame) begin
            if (idx < cur.len) begin
                chk($sformatf("frame_nib%0d", idx), gic_dat_o, cur.v[4*idx +: 4]);
                idx++;
            end else begin
                chk("frame_end_idle", gic_dat_o, 4'hF);
                in_frame = 1'b0;
            end
        end else if (gic_dat_o !== 4'hF) begin
            if (frm_q.size() == 0) begin
                chk("unexpected_frame", gic_dat_o, 4'hF);
            end else begin
                cur = frm_q.pop_front();
                chk("frame_nib0", gic_dat_o, cur.v[3:0]);
                idx = 1;
                in_frame = 1'b1;
            end
        end
    end

    // Result monitor: each pulse is one-hot and matches the next expected reply
    always @(negedge clk) begin
        logic [2:0] p;
        res_t r;
        int k;
        if (!rst) begin
            p = {wbs_ack_o, wbs_err_o, wbs_rty_o};
            if (p != 3'b000) begin
                chk("pulse_onehot", $onehot(p), 1);
                if (exp_q.size() == 0) begin
                    chk("unexpected_pulse", p, 0);
                end else begin
                    r = exp_q.pop_front();
                    k = (p == 3'b100) ? 0 : (p == 3'b010) ? 1 : (p == 3'b001) ? 2 : 3;
                    chk("result_kind", k, r.kind);
                    chk("wbs_dat_o", wbs_dat_o, r.data);
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int dly, b2b;
        bit we, drp;
        logic [3:0] resp, ckx;
        rst = 1'b1; gic_dat_i = 4'hF;
        wbs_adr_i = '0; wbs_dat_i = '0; wbs_sel_i = '0; wbs_we_i = 1'b0;
        wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_cti_i = '0; wbs_bte_i = '0;
        repeat (3) step();
        chk("rst_gic", gic_dat_o, 4'hF);
        chk("rst_pulses", {wbs_ack_o, wbs_err_o, wbs_rty_o}, 3'b000);
        chk("rst_dat", wbs_dat_o, 32'h0);
        rst = 1'b0;
        step();

        // Directed cases from the bring-up plan
        run_txn(1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 2, 4'b1000, 32'h0, 4'h0, 0); drop();
        run_txn(0, 32'h0000_0004, 32'h0, 4'hF, 0, 4'b1000, 32'h1234_5678, 4'h0, 0); drop();
        run_txn(0, 32'h0000_0004, 32'h0, 4'hF, 1, 4'b1000, 32'h1234_5678, 4'h1, 0); drop();
        run_txn(0, 32'h0000_0004, 32'h0, 4'hF, 0, 4'b0010, 32'h0, 4'h0, 0); drop();
        run_txn(0, 32'h0000_0004, 32'h0, 4'hF, 3, 4'b1100, 32'h0, 4'h0, 0); drop();
        run_txn(1, 32'hCAFE_0000, 32'h0BAD_F00D, 4'h3, TMO, 4'b1000, 32'h0, 4'h0, 0); drop();
        gic_dat_i = 4'b0101;
        repeat (3) begin step(); chk("idle_ignores_sinit", gic_dat_o, 4'hF); end
        gic_dat_i = 4'hF;

        // Reset during the 4th address nibble
        mon_off = 1'b1;
        wbs_adr_i = 32'h0ABC_D123; wbs_dat_i = 32'h5555_AAAA; wbs_sel_i = 4'hF;
        wbs_we_i = 1'b1; wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1;
        step();
        chk("rst_mid_init", gic_dat_o, 4'b1010);
        repeat (6) step();
        chk("rst_mid_adr3", gic_dat_o, 4'hC);
        rst = 1'b1; drop();
        step();
        chk("rst_mid_idle", gic_dat_o, 4'hF);
        chk("rst_mid_nopulse", {wbs_ack_o, wbs_err_o, wbs_rty_o}, 3'b000);
        rst = 1'b0;
        step();
        mon_off = 1'b0;
        run_txn(0, 32'h0000_0008, 32'h0, 4'h5, 4, 4'b1000, 32'h8765_4321, 4'h0, 0); drop();

        // cyc abandoned mid-frame, then back-to-back reads with stb held
        run_txn(0, 32'h0000_0020, 32'h0, 4'hF, 2, 4'b1000, 32'hA5A5_0001, 4'h0, 1);
        step();
        run_txn(0, 32'h0000_0030, 32'h0, 4'hF, 1, 4'b1000, 32'h1111_2222, 4'h0, 0);
        run_txn(0, 32'h0000_0034, 32'h0, 4'hC, 0, 4'b1000, 32'h3333_4444, 4'h0, 0); drop();

        // Randomized traffic
        for (int t = 0; t < 40; t++) begin
            we   = 1'($urandom);
            dly  = $urandom_range(0, TMO + 3);
            case ($urandom_range(0, 6))
                0, 1, 2, 3: resp = 4'b1000;
                4:          resp = 4'b0100;
                5:          resp = 4'b0010;
                default:    resp = 4'($urandom);
            endcase
            ckx  = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
            drp  = ($urandom_range(0, 9) == 0);
            run_txn(we, $urandom, $urandom, 4'($urandom), dly, resp, $urandom, ckx, drp);
            b2b = $urandom_range(0, 3);
            if (drp || b2b != 0) begin
                drop();
                repeat ($urandom_range(0, 2)) step();
            end
        end
        drop();
        repeat (5) step();
        chk("frames_left", frm_q.size(), 0);
        chk("results_left", exp_q.size(), 0);
        chk("frame_open", in_frame, 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/gic_master.md
Name: gic_master

Overview:
- Wishbone classic slave that serializes each bus cycle onto the 4-bit Gris InterConnect (GIC) link toward a remote gic_slave, then deserializes the reply.
- Sits at the local bus edge of a GIC bridge. Local Wishbone masters reach the far-side bus through it.
- Handles one transaction in flight at a time.

Parameters:
- idle, 4'b1111, nibble driven on gic_dat_o whenever no frame is being transmitted.
- timeout, 1023, maximum number of WAIT cycles spent waiting for the slave_initiate nibble before failing with err.

Ports:
wbs_clk_i  input  1  clock
wbs_rst_i  input  1  reset; synchronous, active-high
wbs_adr_i  input  32  address
wbs_dat_i  input  32  write data
wbs_sel_i  input  4  byte select
wbs_we_i  input  1  write enable
wbs_stb_i  input  1  strobe
wbs_cyc_i  input  1  cycle
wbs_cti_i  input  3  ignored; classic cycles only
wbs_bte_i  input  2  ignored
wbs_dat_o  output  32  read data
wbs_ack_o  output  1  cycle acknowledge
wbs_err_o  output  1  cycle error
wbs_rty_o  output  1  cycle retry
gic_dat_i  input  4  GIC nibble from slave
gic_dat_o  output  4  GIC nibble to slave

Behaviour:
- Reset values: gic_dat_o=idle; ack/err/rty=0; wbs_dat_o=0; state=IDLE.
- Reset mid-transaction: abort immediately. No ack/err/rty is issued. gic_dat_o=idle from the next cycle.
- IDLE:
  - In cycle T, if cyc_i&stb_i, latch adr, dat, sel, we into registers and move to INIT.
  - Later changes on the inputs have no effect.
- Transmit: one registered nibble per clock.
  - T+1 INIT: 4'b1010.
  - T+2 CMD: {we,3'b000}.
  - T+3 SEL: sel.
  - T+4..T+11 ADR: adr nibbles [31:28] first down to [3:0].
  - Writes only, T+12..T+19 DAT: dat nibbles, MSB nibble first.
  - Next cycle CKSUM: checksum nibble.
  - Then WAIT, driving idle.
- Tx checksum = sel ^ XOR(adr nibbles) ^ 4'b1100, further ^ XOR(dat nibbles) ^ 4'b1100 for writes.
  - The 4'b1100 term is applied once per 8-nibble group.
  - This makes an all-1s or all-0s frame invalid.
- WAIT:
  - Count cycles. gic_dat_i is ignored except to detect 4'b0101.
  - 4'b0101 seen -> RESP on the next cycle.
  - Count reaches timeout -> DONE with err.
- RESP: sample one nibble {ack,err,rty,0}.
  - Valid only if exactly one of bits 3..1 is set and bit0=0; otherwise result = err.
  - If write, or result not ack -> DONE with that result.
  - Otherwise, read with ack -> RDAT.
- RDAT:
  - Sample 8 consecutive nibbles MSB first into a shift register.
  - Accumulate rx checksum, starting at 0 and XORing in each nibble.
- RCKSUM:
  - Compare gic_dat_i to rx_xor ^ 4'b1100.
  - Match -> wbs_dat_o = captured data, result ack.
  - Mismatch -> result err, wbs_dat_o unchanged.
- DONE:
  - Assert exactly one of ack/err/rty for exactly one cycle, then IDLE.
  - A new request can be accepted in the cycle after the pulse, because IDLE samples stb.
- cyc_i dropped mid-transaction: the frame still completes on the link. The DONE pulse is suppressed if cyc_i=0 in DONE.
- gic_dat_o = idle in every state except INIT..CKSUM.
- Internal counters are 3-bit for nibbles and wrap 7->0 to mark group end. The timeout counter is sized by clog2(timeout+1).

Test Plan:
- Write adr=0x00000010 sel=F dat=0xDEADBEEF -> gic_dat_o sequence 1010,1000,1111,0,0,0,0,0,0,1,0,D,E,A,D,B,E,E,F,1110 then 1111; slave replies 0101,1000 -> single wbs_ack_o pulse.
- Read adr=0x00000004 sel=F -> tx 1010,0000,1111,0,0,0,0,0,0,0,4,0111; rx 0101,1000,1..8,0100 -> ack, wbs_dat_o=0x12345678.
- Same read with rx checksum 0101 -> wbs_err_o pulse, wbs_dat_o unchanged; response nibbles 0010 -> rty; 1100 -> err.
- No 0101 within timeout=15 -> err pulse exactly 15 cycles into WAIT; 0101 arriving afterwards ignored in IDLE.
- Assert wbs_rst_i during the 4th address nibble -> gic_dat_o=1111 next cycle, no ack/err/rty; a following transaction completes normally.
- Back-to-back reads with stb held -> second frame's 1010 appears 2 cycles after first ack.
